// File: rtl/shared_ram_mailbox_pkg.sv
// Shared constants for the HPS / RISC-V shared RAM mailbox: port B FSM
// encodings and the doorbell word locations relative to the RAM depth.
package shared_ram_mailbox_pkg;

   // Port B handshake FSM encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   // Number of byte lanes in a word
   function automatic int byte_lanes(input int data_width);
      return data_width / 8;
   endfunction

   // HPS -> RISC-V doorbell lives in the last word
   function automatic int unsigned db_b_word(input int unsigned addr_width);
      return (32'd1 << addr_width) - 32'd1;
   endfunction

   // RISC-V -> HPS doorbell lives in the second-to-last word
   function automatic int unsigned db_a_word(input int unsigned addr_width);
      return (32'd1 << addr_width) - 32'd2;
   endfunction

endpackage

// File: rtl/shared_ram_mailbox_if.sv
// Bus bundle for both mailbox ports: the stateless HPS port (suffix _a) and
// the handshaked RISC-V port (suffix _b).
interface shared_ram_mailbox_if
   import shared_ram_mailbox_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
);
   localparam int NB = byte_lanes(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] data_a;
   logic [ADDR_WIDTH-1:0] addr_a;
   logic [NB-1:0]         we_a;
   logic [DATA_WIDTH-1:0] q_a;

   logic                  mem_valid_b;
   logic                  mem_ready_b;
   logic [DATA_WIDTH-1:0] data_b;
   logic [ADDR_WIDTH-1:0] addr_b;
   logic [NB-1:0]         we_b;
   logic [DATA_WIDTH-1:0] q_b;

   modport master (
      output data_a, addr_a, we_a, mem_valid_b, data_b, addr_b, we_b,
      input  q_a, mem_ready_b, q_b
   );

   modport slave (
      input  data_a, addr_a, we_a, mem_valid_b, data_b, addr_b, we_b,
      output q_a, mem_ready_b, q_b
   );
endinterface

// File: rtl/shared_ram_mailbox_tdp_ram.sv
// Single-clock true dual-port RAM, read-first on both ports (a read of an
// address being written in the same cycle returns the old contents).
module shared_ram_mailbox_tdp_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic [DATA_WIDTH-1:0] data_a,
   input  logic [DATA_WIDTH-1:0] data_b,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic                  we_a,
   input  logic                  we_b,
   output logic [DATA_WIDTH-1:0] q_a,
   output logic [DATA_WIDTH-1:0] q_b
);
   logic [DATA_WIDTH-1:0] ram [0:(1 << ADDR_WIDTH)-1];

   // Both ports in one process; port A is written last so it would win a shared address
   always_ff @(posedge clk) begin
      if (we_b) ram[addr_b] <= data_b;
      if (we_a) ram[addr_a] <= data_a;
      q_a <= ram[addr_a];
      q_b <= ram[addr_b];
   end
endmodule

// File: rtl/shared_ram_mailbox.sv
// Dual-port shared memory between the HPS (port A, stateless) and the RISC-V
// core (port B, valid/ready handshake). Adds an optional output register,
// port A priority on colliding byte lanes, and two doorbell interrupt flags.
module shared_ram_mailbox
   import shared_ram_mailbox_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 6,
   parameter int READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                resetn,
   shared_ram_mailbox_if.slave bus,
   output logic                irq_a,
   output logic                irq_b,
   output logic                collision,
   input  logic                collision_clr
);
   localparam int NB = byte_lanes(DATA_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] DB_B = ADDR_WIDTH'(db_b_word(ADDR_WIDTH));
   localparam logic [ADDR_WIDTH-1:0] DB_A = ADDR_WIDTH'(db_a_word(ADDR_WIDTH));

   generate
      if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
         $error("shared_ram_mailbox: READ_LATENCY must be 1 or 2");
      end
      if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 128) begin : g_bad_width
         $error("shared_ram_mailbox: DATA_WIDTH must be a multiple of 8 in 8..128");
      end
      if (ADDR_WIDTH < 1) begin : g_bad_addr
         $error("shared_ram_mailbox: ADDR_WIDTH must give at least 2 words");
      end
   endgenerate

   logic [1:0]            state_reg, state_next;
   logic [ADDR_WIDTH-1:0] addr_lat_reg;
   logic                  write_lat_reg;
   logic                  irq_a_reg, irq_b_reg, collision_reg;

   logic                  b_fire;
   logic                  same_addr;
   logic                  collide;
   logic [NB-1:0]         we_b_eff;
   logic [DATA_WIDTH-1:0] ram_q_a, ram_q_b;
   logic [DATA_WIDTH-1:0] q_a_int, q_b_int;

   // Port B is accepted only in IDLE; its write is applied in that same cycle
   assign b_fire    = (state_reg == ST_IDLE) && bus.mem_valid_b;
   assign same_addr = (bus.addr_a == bus.addr_b);
   assign collide   = b_fire && same_addr && (|(bus.we_a & bus.we_b));
   // Port A owns any byte lane both ports write at the same address
   assign we_b_eff  = b_fire ? (same_addr ? (bus.we_b & ~bus.we_a) : bus.we_b) : '0;

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane
         shared_ram_mailbox_tdp_ram #(
            .DATA_WIDTH(8),
            .ADDR_WIDTH(ADDR_WIDTH)
         ) u_lane (
            .clk    (clk),
            .data_a (bus.data_a[gi*8 +: 8]),
            .data_b (bus.data_b[gi*8 +: 8]),
            .addr_a (bus.addr_a),
            .addr_b (bus.addr_b),
            .we_a   (bus.we_a[gi]),
            .we_b   (we_b_eff[gi]),
            .q_a    (ram_q_a[gi*8 +: 8]),
            .q_b    (ram_q_b[gi*8 +: 8])
         );
      end
   endgenerate

   generate
      if (READ_LATENCY == 2) begin : g_out_reg
         logic [DATA_WIDTH-1:0] q_a_reg, q_b_reg;
         // Extra output register on both ports; data path only, no reset needed
         always_ff @(posedge clk) begin
            q_a_reg <= ram_q_a;
            q_b_reg <= ram_q_b;
         end
         assign q_a_int = q_a_reg;
         assign q_b_int = q_b_reg;
      end else begin : g_out_raw
         assign q_a_int = ram_q_a;
         assign q_b_int = ram_q_b;
      end
   endgenerate

   // Port B sequencing: IDLE -> (WAIT when latency 2) -> ACK -> IDLE
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (bus.mem_valid_b) state_next = (READ_LATENCY == 2) ? ST_WAIT : ST_ACK;
         ST_WAIT: state_next = ST_ACK;
         ST_ACK:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM state plus the request details needed later for the doorbell clear
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg     <= ST_IDLE;
         addr_lat_reg  <= '0;
         write_lat_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (b_fire) begin
            addr_lat_reg  <= bus.addr_b;
            write_lat_reg <= |bus.we_b;
         end
      end
   end

   logic irq_b_set, irq_b_clr, irq_a_set, irq_a_clr;
   assign irq_b_set = (|bus.we_a) && (bus.addr_a == DB_B);
   assign irq_b_clr = (state_reg == ST_ACK) && !write_lat_reg && (addr_lat_reg == DB_B);
   assign irq_a_set = b_fire && (|bus.we_b) && (bus.addr_b == DB_A);
   assign irq_a_clr = (bus.we_a == '0) && (bus.addr_a == DB_A);

   // Doorbell and collision flags; a set in the same cycle as a clear wins
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         irq_a_reg     <= 1'b0;
         irq_b_reg     <= 1'b0;
         collision_reg <= 1'b0;
      end else begin
         irq_a_reg     <= irq_a_set | (irq_a_reg & ~irq_a_clr);
         irq_b_reg     <= irq_b_set | (irq_b_reg & ~irq_b_clr);
         collision_reg <= collide   | (collision_reg & ~collision_clr);
      end
   end

   assign bus.mem_ready_b = (state_reg == ST_ACK);
   assign bus.q_b         = bus.mem_ready_b ? q_b_int : '0;
   assign bus.q_a         = q_a_int;
   assign irq_a           = irq_a_reg;
   assign irq_b           = irq_b_reg;
   assign collision       = collision_reg;

endmodule

// File: tb/tb_shared_ram_mailbox.sv
// Directed bench for shared_ram_mailbox: one instance with 32-bit words and
// latency 1, one with 64-bit words and latency 2, driven and sampled on the
// falling clock edge.
module tb_shared_ram_mailbox;
   logic clk = 1'b0;
   logic resetn;
   logic clr1, clr2;
   logic irq_a1, irq_b1, col1;
   logic irq_a2, irq_b2, col2;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   shared_ram_mailbox_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) bus1 ();
   shared_ram_mailbox_if #(.DATA_WIDTH(64), .ADDR_WIDTH(4)) bus2 ();

   shared_ram_mailbox #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .READ_LATENCY(1)) dut1 (
      .clk(clk), .resetn(resetn), .bus(bus1), .irq_a(irq_a1), .irq_b(irq_b1),
      .collision(col1), .collision_clr(clr1)
   );

   shared_ram_mailbox #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .READ_LATENCY(2)) dut2 (
      .clk(clk), .resetn(resetn), .bus(bus2), .irq_a(irq_a2), .irq_b(irq_b2),
      .collision(col2), .collision_clr(clr2)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic a1_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] we);
      bus1.addr_a = addr; bus1.data_a = data; bus1.we_a = we;
      @(negedge clk);
      bus1.we_a = 4'h0; bus1.addr_a = 6'd0;
   endtask

   task automatic a2_write(input logic [3:0] addr, input logic [63:0] data, input logic [7:0] we);
      bus2.addr_a = addr; bus2.data_a = data; bus2.we_a = we;
      @(negedge clk);
      bus2.we_a = 8'h0; bus2.addr_a = 4'd0;
   endtask

   task automatic b1_txn(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] we,
                         output logic [31:0] q, output int lat);
      bus1.mem_valid_b = 1'b1; bus1.addr_b = addr; bus1.data_b = data; bus1.we_b = we;
      lat = 99; q = '0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         bus1.mem_valid_b = 1'b0; bus1.we_b = 4'h0;
         if (bus1.mem_ready_b) begin
            lat = i; q = bus1.q_b;
            break;
         end
      end
      $display("txn dut1 addr=%0d we=0x%0h q=0x%08h latency=%0d", addr, we, q, lat);
      @(negedge clk);
      check_eq("dut1 ready single pulse", 64'(bus1.mem_ready_b), 64'h0);
      check_eq("dut1 q_b zero after ack", 64'(bus1.q_b), 64'h0);
   endtask

   task automatic b2_txn(input logic [3:0] addr, input logic [63:0] data, input logic [7:0] we,
                         output logic [63:0] q, output int lat);
      bus2.mem_valid_b = 1'b1; bus2.addr_b = addr; bus2.data_b = data; bus2.we_b = we;
      lat = 99; q = '0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         bus2.mem_valid_b = 1'b0; bus2.we_b = 8'h0;
         if (bus2.mem_ready_b) begin
            lat = i; q = bus2.q_b;
            break;
         end
      end
      $display("txn dut2 addr=%0d we=0x%0h q=0x%016h latency=%0d", addr, we, q, lat);
      @(negedge clk);
      check_eq("dut2 ready single pulse", 64'(bus2.mem_ready_b), 64'h0);
      check_eq("dut2 q_b zero after ack", 64'(bus2.q_b), 64'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] q1;
      logic [63:0] q2;
      int          lat;
      logic [5:0]  ready_mask;
      logic        late_ready;

      resetn = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
      bus1.data_a = '0; bus1.addr_a = '0; bus1.we_a = '0;
      bus1.mem_valid_b = 1'b0; bus1.data_b = '0; bus1.addr_b = '0; bus1.we_b = '0;
      bus2.data_a = '0; bus2.addr_a = '0; bus2.we_a = '0;
      bus2.mem_valid_b = 1'b0; bus2.data_b = '0; bus2.addr_b = '0; bus2.we_b = '0;
      repeat (3) @(negedge clk);

      // Reset values
      check_eq("dut1 reset ready", 64'(bus1.mem_ready_b), 64'h0);
      check_eq("dut1 reset q_b", 64'(bus1.q_b), 64'h0);
      check_eq("dut1 reset irq_a", 64'(irq_a1), 64'h0);
      check_eq("dut1 reset irq_b", 64'(irq_b1), 64'h0);
      check_eq("dut1 reset collision", 64'(col1), 64'h0);
      check_eq("dut2 reset ready", 64'(bus2.mem_ready_b), 64'h0);
      check_eq("dut2 reset irqs", 64'({irq_a2, irq_b2, col2}), 64'h0);
      resetn = 1'b1;
      @(negedge clk);

      // Basic A write, B read at latency 1
      a1_write(6'd3, 32'hDEADBEEF, 4'hF);
      b1_txn(6'd3, 32'h0, 4'h0, q1, lat);
      check_eq("dut1 read latency", 64'(lat), 64'd1);
      check_eq("dut1 read data", 64'(q1), 64'hDEADBEEF);
      bus1.addr_a = 6'd3;
      @(negedge clk);
      check_eq("dut1 q_a read", 64'(bus1.q_a), 64'hDEADBEEF);
      bus1.addr_a = 6'd0;

      // Collision: A lanes 0,1 and B lanes 1,2 on address 5
      a1_write(6'd5, 32'h0, 4'hF);
      bus1.addr_a = 6'd5; bus1.data_a = 32'h11111111; bus1.we_a = 4'h3;
      b1_txn(6'd5, 32'h22222222, 4'h6, q1, lat);
      bus1.we_a = 4'h0; bus1.addr_a = 6'd0;
      check_eq("dut1 collision flag", 64'(col1), 64'h1);
      b1_txn(6'd5, 32'h0, 4'h0, q1, lat);
      check_eq("dut1 collision merge", 64'(q1), 64'h00221111);
      check_eq("dut1 collision sticky", 64'(col1), 64'h1);
      clr1 = 1'b1;
      @(negedge clk);
      clr1 = 1'b0;
      check_eq("dut1 collision cleared", 64'(col1), 64'h0);

      // New collision in the same cycle as a clear keeps the flag set
      bus1.addr_a = 6'd9; bus1.data_a = 32'h55; bus1.we_a = 4'h1; clr1 = 1'b1;
      bus1.mem_valid_b = 1'b1; bus1.addr_b = 6'd9; bus1.data_b = 32'h66; bus1.we_b = 4'h1;
      @(negedge clk);
      bus1.we_a = 4'h0; bus1.addr_a = 6'd0; clr1 = 1'b0;
      bus1.mem_valid_b = 1'b0; bus1.we_b = 4'h0;
      check_eq("dut1 collision set beats clear", 64'(col1), 64'h1);
      @(negedge clk);
      clr1 = 1'b1;
      @(negedge clk);
      clr1 = 1'b0;
      check_eq("dut1 collision cleared again", 64'(col1), 64'h0);

      // Doorbell to RISC-V (DB_B = 63)
      a1_write(6'd63, 32'h1, 4'h1);
      check_eq("dut1 irq_b set", 64'(irq_b1), 64'h1);
      b1_txn(6'd63, 32'h0, 4'h0, q1, lat);
      check_eq("dut1 irq_b cleared by read", 64'(irq_b1), 64'h0);
      a1_write(6'd63, 32'h2, 4'h1);
      bus1.mem_valid_b = 1'b1; bus1.addr_b = 6'd63; bus1.we_b = 4'h0;
      @(negedge clk);
      bus1.mem_valid_b = 1'b0;
      check_eq("dut1 ack with db read", 64'(bus1.mem_ready_b), 64'h1);
      bus1.addr_a = 6'd63; bus1.data_a = 32'h3; bus1.we_a = 4'h1;
      @(negedge clk);
      bus1.we_a = 4'h0; bus1.addr_a = 6'd0;
      check_eq("dut1 irq_b set beats clear", 64'(irq_b1), 64'h1);

      // Doorbell to HPS (DB_A = 62)
      b1_txn(6'd62, 32'hA5A50001, 4'hF, q1, lat);
      check_eq("dut1 write latency", 64'(lat), 64'd1);
      check_eq("dut1 irq_a set", 64'(irq_a1), 64'h1);
      bus1.addr_a = 6'd62;
      @(negedge clk);
      bus1.addr_a = 6'd0;
      check_eq("dut1 irq_a cleared by read", 64'(irq_a1), 64'h0);
      check_eq("dut1 q_a db_a word", 64'(bus1.q_a), 64'hA5A50001);

      // Latency 2, 64-bit: partial B write then read back
      a2_write(4'd7, 64'h0, 8'hFF);
      a2_write(4'd8, 64'h0CAFE, 8'hFF);
      b2_txn(4'd7, 64'h0123456789ABCDEF, 8'h0F, q2, lat);
      check_eq("dut2 write latency", 64'(lat), 64'd2);
      b2_txn(4'd7, 64'h0, 8'h00, q2, lat);
      check_eq("dut2 read latency", 64'(lat), 64'd2);
      check_eq("dut2 partial write", q2, 64'h0000000089ABCDEF);

      // Port A read latency 2
      bus2.addr_a = 4'd8;
      repeat (2) @(negedge clk);
      bus2.addr_a = 4'd7;
      @(negedge clk);
      check_eq("dut2 q_a old after 1 cycle", bus2.q_a, 64'h0CAFE);
      @(negedge clk);
      check_eq("dut2 q_a after 2 cycles", bus2.q_a, 64'h0000000089ABCDEF);
      bus2.addr_a = 4'd0;

      // Back-to-back requests with valid held high complete every 3 cycles
      ready_mask = '0;
      bus2.mem_valid_b = 1'b1; bus2.addr_b = 4'd7; bus2.we_b = 8'h0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (bus2.mem_ready_b) begin
            ready_mask[k-1] = 1'b1;
            check_eq("dut2 back-to-back data", bus2.q_b, 64'h0000000089ABCDEF);
         end
         if (k == 5) bus2.mem_valid_b = 1'b0;
      end
      $display("txn dut2 back-to-back ready_mask=%b", ready_mask);
      check_eq("dut2 back-to-back spacing", 64'(ready_mask), 64'b010010);

      // Doorbell to HPS on dut2 (DB_A = 14), left set for the reset test
      b2_txn(4'd14, 64'h1, 8'h01, q2, lat);
      check_eq("dut2 irq_a set", 64'(irq_a2), 64'h1);

      // Reset while the FSM is in WAIT with flags set
      a2_write(4'd15, 64'h0, 8'hFF);
      check_eq("dut2 irq_b set", 64'(irq_b2), 64'h1);
      bus2.addr_a = 4'd15; bus2.data_a = 64'hAA; bus2.we_a = 8'h01;
      bus2.mem_valid_b = 1'b1; bus2.addr_b = 4'd15; bus2.data_b = 64'hBB; bus2.we_b = 8'h01;
      @(negedge clk);
      bus2.we_a = 8'h0; bus2.addr_a = 4'd0; bus2.mem_valid_b = 1'b0; bus2.we_b = 8'h0;
      check_eq("dut2 collision before reset", 64'(col2), 64'h1);
      check_eq("dut2 in wait, no ready", 64'(bus2.mem_ready_b), 64'h0);
      #2 resetn = 1'b0;
      #1;
      check_eq("dut2 async reset ready", 64'(bus2.mem_ready_b), 64'h0);
      check_eq("dut2 async reset irq_a", 64'(irq_a2), 64'h0);
      check_eq("dut2 async reset irq_b", 64'(irq_b2), 64'h0);
      check_eq("dut2 async reset collision", 64'(col2), 64'h0);
      @(negedge clk);
      resetn = 1'b1;
      late_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus2.mem_ready_b) late_ready = 1'b1;
      end
      check_eq("dut2 no ready after reset", 64'(late_ready), 64'h0);
      b2_txn(4'd15, 64'h0, 8'h00, q2, lat);
      check_eq("dut2 committed write kept", q2 & 64'hFF, 64'hAA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
